// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
//  Register-port bus between the transmit sequencer (master) and uart_regs (slave).
//  wb_addr_o  3  register address
//  wb_dat_o   8  write data
//  wb_dat_i   8  read data, combinational from the addressed register
//  wb_we_o    1  write strobe, one cycle per access
//  wb_re_o    1  read strobe, one cycle per access
interface uart_tx_sched_if;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_re_o;

  modport master (output wb_addr_o, wb_dat_o, wb_we_o, wb_re_o, input wb_dat_i);
  modport slave  (input wb_addr_o, wb_dat_o, wb_we_o, wb_re_o, output wb_dat_i);
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//  Sole bus master of uart_regs. After reset it programs LCR/DL/FCR, then shares the
//  transmit FIFO among NREQ byte-stream requesters in round-robin bursts of up to BURST
//  bytes, polling LSR.THRE before each burst.
// Ports
//  clk        system clock
//  wb_rst_ni  asynchronous active-low reset
//  wb         register bus (master modport)
//  cfg_start  pulse: rerun the configuration sequence (only honoured in IDLE)
//  req_valid  per-requester byte available
//  req_data   byte of requester i at [8i+7:8i]
//  req_ready  one-hot: byte of requester i is written to THR this cycle
//  cfg_done   configuration complete
//  busy       sequencer not in IDLE
//  grant_id   current/last grantee
//  lsr_err    one-cycle pulse: polled LSR had an error/status bit (1,2,3,4,7) set
module uart_tx_sched #(
  parameter int          NREQ     = 4,
  parameter int          BURST    = 16,
  parameter logic [15:0] DIVISOR  = 16'd27,
  parameter logic [7:0]  LCR_INIT = 8'h03,
  parameter logic [7:0]  FCR_INIT = 8'hC6
) (
  input  logic                clk,
  input  logic                wb_rst_ni,
  uart_tx_sched_if.master     wb,
  input  logic                cfg_start,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                cfg_done,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic                lsr_err
);
  localparam int               CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [2:0]       LAST_C  = 3'(NREQ - 1);

  typedef enum logic [3:0] {
    S_CFG_LCR_DLAB, S_CFG_DLL, S_CFG_DLM, S_CFG_LCR, S_CFG_FCR,
    S_IDLE, S_POLL, S_ARB, S_BURST
  } state_t;

  state_t           state_q, state_d;
  logic             run_q;
  logic             cfg_done_q, cfg_done_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lsr_err_q, lsr_err_d;

  logic [2:0]       addr;
  logic [7:0]       dat;
  logic             we, re;

  // Byte and valid of the current grantee.
  logic       g_valid;
  logic [7:0] g_byte;
  always_comb begin
    g_valid = 1'b0;
    g_byte  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == 3'(i)) begin
        g_valid = req_valid[i];
        g_byte  = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin pick: lowest valid index at or above rr_q, otherwise lowest valid overall
  // (the wrap-around case). Scanning downward leaves the lowest hit in each candidate.
  logic       arb_found, hi_found;
  logic [2:0] hi_idx, lo_idx, arb_idx;
  always_comb begin
    arb_found = 1'b0;
    hi_found  = 1'b0;
    hi_idx    = 3'd0;
    lo_idx    = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        arb_found = 1'b1;
        lo_idx    = 3'(i);
        if (3'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
    arb_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d    = state_q;
    cfg_done_d = cfg_done_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    lsr_err_d  = 1'b0;
    addr       = 3'd0;
    dat        = 8'h00;
    we         = 1'b0;
    re         = 1'b0;
    req_ready  = '0;
    // run_q holds everything quiet for the first cycle after reset release, so the bus
    // stays at zero while reset is asserted even though the state is already CFG_LCR_DLAB.
    if (run_q) begin
      unique case (state_q)
        S_CFG_LCR_DLAB: begin
          we = 1'b1; addr = 3'd3; dat = LCR_INIT | 8'h80; state_d = S_CFG_DLL;
        end
        S_CFG_DLL: begin
          we = 1'b1; addr = 3'd0; dat = DIVISOR[7:0];     state_d = S_CFG_DLM;
        end
        S_CFG_DLM: begin
          we = 1'b1; addr = 3'd1; dat = DIVISOR[15:8];    state_d = S_CFG_LCR;
        end
        S_CFG_LCR: begin
          we = 1'b1; addr = 3'd3; dat = LCR_INIT;         state_d = S_CFG_FCR;
        end
        S_CFG_FCR: begin
          we = 1'b1; addr = 3'd2; dat = FCR_INIT;
          cfg_done_d = 1'b1;
          state_d    = S_IDLE;
        end
        S_IDLE: begin
          if (cfg_start) begin
            cfg_done_d = 1'b0;
            state_d    = S_CFG_LCR_DLAB;
          end else if (|req_valid) begin
            state_d = S_POLL;
          end
        end
        S_POLL: begin
          re        = 1'b1;
          addr      = 3'd5;
          lsr_err_d = |(wb.wb_dat_i & 8'h9E);
          if (wb.wb_dat_i[5]) state_d = S_ARB;
        end
        S_ARB: begin
          if (arb_found) begin
            grant_d = arb_idx;
            cnt_d   = '0;
            state_d = S_BURST;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BURST: begin
          if (g_valid) begin
            we    = 1'b1;
            addr  = 3'd0;
            dat   = g_byte;
            cnt_d = cnt_q + CNT_W'(1);
            for (int i = 0; i < NREQ; i++) req_ready[i] = (grant_q == 3'(i));
          end
          // The last byte of a full burst exits in the same cycle it is written.
          if (!g_valid || cnt_d == BURST_C) begin
            rr_d    = (grant_q == LAST_C) ? 3'd0 : grant_q + 3'd1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_CFG_LCR_DLAB;
      run_q      <= 1'b0;
      cfg_done_q <= 1'b0;
      grant_q    <= 3'd0;
      rr_q       <= 3'd0;
      cnt_q      <= '0;
      lsr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      cfg_done_q <= cfg_done_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      lsr_err_q  <= lsr_err_d;
    end
  end

  assign wb.wb_addr_o = addr;
  assign wb.wb_dat_o  = dat;
  assign wb.wb_we_o   = we;
  assign wb.wb_re_o   = re;
  assign cfg_done     = cfg_done_q;
  assign busy         = run_q && (state_q != S_IDLE);
  assign grant_id     = grant_q;
  assign lsr_err      = lsr_err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: dut_a uses BURST=16, dut_b uses BURST=4.
module tb_uart_tx_sched;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if bus_a ();
  uart_tx_sched_if bus_b ();

  logic              cfg_start_a, cfg_start_b;
  logic [NREQ-1:0]   valid_a, valid_b, ready_a, ready_b;
  logic [8*NREQ-1:0] data_a, data_b;
  logic              done_a, done_b, busy_a, busy_b, err_a, err_b;
  logic [2:0]        gid_a, gid_b;
  logic [7:0]        lsr_a, lsr_b;

  assign bus_a.wb_dat_i = lsr_a;
  assign bus_b.wb_dat_i = lsr_b;

  uart_tx_sched #(.NREQ(NREQ), .BURST(16)) dut_a (
    .clk(clk), .wb_rst_ni(rst_n), .wb(bus_a), .cfg_start(cfg_start_a),
    .req_valid(valid_a), .req_data(data_a), .req_ready(ready_a),
    .cfg_done(done_a), .busy(busy_a), .grant_id(gid_a), .lsr_err(err_a)
  );

  uart_tx_sched #(.NREQ(NREQ), .BURST(4)) dut_b (
    .clk(clk), .wb_rst_ni(rst_n), .wb(bus_b), .cfg_start(cfg_start_b),
    .req_valid(valid_b), .req_data(data_b), .req_ready(ready_b),
    .cfg_done(done_b), .busy(busy_b), .grant_id(gid_b), .lsr_err(err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {lsr_err, addr, dat, we, re, cfg_done, busy, ready, grant_id}
  function automatic logic [22:0] mk(input logic e, input logic [2:0] a, input logic [7:0] d,
                                     input logic w, input logic r, input logic dn,
                                     input logic b, input logic [3:0] rdy, input logic [2:0] g);
    return {e, a, d, w, r, dn, b, rdy, g};
  endfunction

  function automatic logic [22:0] outs(input bit sel_b);
    if (sel_b)
      return {err_b, bus_b.wb_addr_o, bus_b.wb_dat_o, bus_b.wb_we_o, bus_b.wb_re_o,
              done_b, busy_b, ready_b, gid_b};
    return {err_a, bus_a.wb_addr_o, bus_a.wb_dat_o, bus_a.wb_we_o, bus_a.wb_re_o,
            done_a, busy_a, ready_a, gid_a};
  endfunction

  typedef struct packed {
    logic [3:0]  valid;
    logic [7:0]  lsr;
    logic [22:0] exp;
  } vec_t;

  vec_t       vt [15];
  logic [7:0] bdat [NREQ];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_start_a = 1'b0; cfg_start_b = 1'b0;
    valid_a = '0; valid_b = '0;
    data_a = '0;
    data_b = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bdat[0] = 8'hA0; bdat[1] = 8'hB1; bdat[2] = 8'hC2; bdat[3] = 8'hD3;
    lsr_a = 8'h60; lsr_b = 8'h60;

    // Reset release, configuration, then one full 4-byte burst from requester 0.
    vt[0]  = {4'b0000, 8'h60, mk(0, 3'd0, 8'h00, 0, 0, 0, 0, 4'b0000, 3'd0)};
    vt[1]  = {4'b0000, 8'h60, mk(0, 3'd3, 8'h83, 1, 0, 0, 1, 4'b0000, 3'd0)};
    vt[2]  = {4'b0000, 8'h60, mk(0, 3'd0, 8'h1B, 1, 0, 0, 1, 4'b0000, 3'd0)};
    vt[3]  = {4'b0000, 8'h60, mk(0, 3'd1, 8'h00, 1, 0, 0, 1, 4'b0000, 3'd0)};
    vt[4]  = {4'b0000, 8'h60, mk(0, 3'd3, 8'h03, 1, 0, 0, 1, 4'b0000, 3'd0)};
    vt[5]  = {4'b0000, 8'h60, mk(0, 3'd2, 8'hC6, 1, 0, 0, 1, 4'b0000, 3'd0)};
    vt[6]  = {4'b0000, 8'h60, mk(0, 3'd0, 8'h00, 0, 0, 1, 0, 4'b0000, 3'd0)};
    vt[7]  = {4'b0001, 8'h60, mk(0, 3'd0, 8'h00, 0, 0, 1, 0, 4'b0000, 3'd0)};
    vt[8]  = {4'b0001, 8'h60, mk(0, 3'd5, 8'h00, 0, 1, 1, 1, 4'b0000, 3'd0)};
    vt[9]  = {4'b0001, 8'h60, mk(0, 3'd0, 8'h00, 0, 0, 1, 1, 4'b0000, 3'd0)};
    vt[10] = {4'b0001, 8'h60, mk(0, 3'd0, 8'hA0, 1, 0, 1, 1, 4'b0001, 3'd0)};
    vt[11] = {4'b0001, 8'h60, mk(0, 3'd0, 8'hA0, 1, 0, 1, 1, 4'b0001, 3'd0)};
    vt[12] = {4'b0001, 8'h60, mk(0, 3'd0, 8'hA0, 1, 0, 1, 1, 4'b0001, 3'd0)};
    vt[13] = {4'b0001, 8'h60, mk(0, 3'd0, 8'hA0, 1, 0, 1, 1, 4'b0001, 3'd0)};
    vt[14] = {4'b0000, 8'h60, mk(0, 3'd0, 8'h00, 0, 0, 1, 0, 4'b0000, 3'd0)};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs_a", outs(0), '0);
    chk("rst_outs_b", outs(1), '0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      valid_b = vt[i].valid;
      lsr_b   = vt[i].lsr;
      #1;
      chk($sformatf("vec%0d", i), outs(1), vt[i].exp);
    end
    chk("a_cfg_done", {done_a, busy_a}, 2'b10);

    // dut_a: 20 bytes from requester 0 -> 16 back-to-back, 3 overhead cycles, 4 more.
    begin
      int sent = 0;
      int nw = 0;
      int wcyc [20];
      for (int k = 0; k < 20; k++) wcyc[k] = 0;
      for (int cyc = 0; cyc < 80 && nw < 20; cyc++) begin
        @(negedge clk);
        valid_a[0]   = (sent < 20);
        data_a[7:0]  = 8'h10 + 8'(sent);
        #1;
        if (bus_a.wb_we_o) begin
          chk("a_wr", {bus_a.wb_addr_o, bus_a.wb_dat_o, ready_a},
              {3'd0, 8'h10 + 8'(nw), 4'b0001});
          wcyc[nw] = cyc;
          nw++;
        end
        if (ready_a[0]) sent++;
      end
      chk("a_nwrites", nw, 20);
      for (int k = 1; k < 20; k++)
        chk($sformatf("a_gap%0d", k), wcyc[k] - wcyc[k-1], (k == 16) ? 4 : 1);
      @(negedge clk);
      valid_a = '0;
    end

    // dut_b: requesters 1 and 3 continuously -> grants 1,3,1,3, 4 bytes each.
    begin
      int nw = 0;
      int last = 0;
      for (int cyc = 0; cyc < 80 && nw < 16; cyc++) begin
        @(negedge clk);
        valid_b = 4'b1010;
        #1;
        chk("b_excl", bus_b.wb_we_o & bus_b.wb_re_o, 1'b0);
        if (bus_b.wb_we_o) begin
          int g;
          g = ((nw / 4) % 2 == 1) ? 3 : 1;
          chk($sformatf("b_rr_w%0d", nw), {bus_b.wb_dat_o, ready_b, gid_b},
              {bdat[g], 4'(1 << g), 3'(g)});
          if (nw > 0) chk($sformatf("b_rr_gap%0d", nw), cyc - last, (nw % 4 == 0) ? 4 : 1);
          last = cyc;
          nw++;
        end
      end
      chk("b_rr_nwrites", nw, 16);
      @(negedge clk);
      valid_b = '0;
      @(negedge clk);
    end

    // LSR 00 for three polls, then 60: four reads before the first write.
    begin
      int reads = 0;
      int rb = -1;
      int errs = 0;
      for (int cyc = 0; cyc < 40 && rb < 0; cyc++) begin
        @(negedge clk);
        valid_b = 4'b0001;
        lsr_b   = (reads < 3) ? 8'h00 : 8'h60;
        #1;
        if (err_b) errs++;
        if (bus_b.wb_we_o) rb = reads;
        if (bus_b.wb_re_o) reads++;
      end
      chk("b_poll_reads", rb, 4);
      chk("b_poll_noerr", errs, 0);
      @(negedge clk);
      valid_b = '0;
      lsr_b   = 8'h60;
      @(negedge clk);
    end

    // LSR 62: one lsr_err pulse the cycle after the read, burst still proceeds.
    begin
      int nw = 0;
      int rcyc = -10;
      int ecyc = -10;
      int errs = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
        @(negedge clk);
        valid_b = (nw < 4) ? 4'b0001 : 4'b0000;
        lsr_b   = 8'h62;
        #1;
        if (bus_b.wb_re_o) rcyc = cyc;
        if (err_b) begin
          errs++;
          ecyc = cyc;
        end
        if (bus_b.wb_we_o) nw++;
      end
      chk("b_err_count", errs, 1);
      chk("b_err_timing", ecyc - rcyc, 1);
      chk("b_err_writes", nw, 4);
      lsr_b = 8'h60;
    end

    // cfg_start during a burst is ignored.
    begin
      int nw = 0;
      int first = -1;
      int last = -1;
      int bad = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
        @(negedge clk);
        valid_b     = (nw < 4) ? 4'b0001 : 4'b0000;
        cfg_start_b = (nw == 2);
        #1;
        if (!done_b) bad++;
        if (bus_b.wb_we_o) begin
          if (bus_b.wb_addr_o != 3'd0) bad++;
          if (first < 0) first = cyc;
          last = cyc;
          nw++;
        end
      end
      cfg_start_b = 1'b0;
      chk("b_cfgburst_writes", nw, 4);
      chk("b_cfgburst_span", last - first, 3);
      chk("b_cfgburst_nocfg", bad, 0);
    end

    // cfg_start in IDLE with a request pending: configuration runs first.
    begin
      logic [22:0] ex [10];
      @(negedge clk);
      #1;
      chk("b_idle_before_cfg", busy_b, 1'b0);
      ex[0] = mk(0, 3'd0, 8'h00, 0, 0, 1, 0, 4'b0000, 3'd0);
      ex[1] = mk(0, 3'd3, 8'h83, 1, 0, 0, 1, 4'b0000, 3'd0);
      ex[2] = mk(0, 3'd0, 8'h1B, 1, 0, 0, 1, 4'b0000, 3'd0);
      ex[3] = mk(0, 3'd1, 8'h00, 1, 0, 0, 1, 4'b0000, 3'd0);
      ex[4] = mk(0, 3'd3, 8'h03, 1, 0, 0, 1, 4'b0000, 3'd0);
      ex[5] = mk(0, 3'd2, 8'hC6, 1, 0, 0, 1, 4'b0000, 3'd0);
      ex[6] = mk(0, 3'd0, 8'h00, 0, 0, 1, 0, 4'b0000, 3'd0);
      ex[7] = mk(0, 3'd5, 8'h00, 0, 1, 1, 1, 4'b0000, 3'd0);
      ex[8] = mk(0, 3'd0, 8'h00, 0, 0, 1, 1, 4'b0000, 3'd0);
      ex[9] = mk(0, 3'd0, 8'hA0, 1, 0, 1, 1, 4'b0001, 3'd0);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        cfg_start_b = (c == 0);
        valid_b     = 4'b0001;
        #1;
        chk($sformatf("b_recfg%0d", c), outs(1), ex[c]);
      end
      @(negedge clk);
      cfg_start_b = 1'b0;
      valid_b     = '0;
      repeat (2) @(negedge clk);
    end

    // Asynchronous reset in the middle of a burst from requester 2.
    begin
      bit seen = 1'b0;
      for (int cyc = 0; cyc < 12 && !seen; cyc++) begin
        @(negedge clk);
        valid_b = 4'b0100;
        #1;
        if (bus_b.wb_we_o) begin
          seen = 1'b1;
          chk("b_midburst_wr", {bus_b.wb_dat_o, ready_b, gid_b}, {8'hC2, 4'b0100, 3'd2});
        end
      end
      chk("b_midburst_seen", seen, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("b_async_rst", outs(1), '0);
      chk("a_async_rst", outs(0), '0);
      @(negedge clk);
      valid_b = '0;
      rst_n   = 1'b1;
      #1;
      chk("b_rel0", outs(1), '0);
      @(negedge clk);
      #1;
      chk("b_rel1", outs(1), mk(0, 3'd3, 8'h83, 1, 0, 0, 1, 4'b0000, 3'd0));
      @(negedge clk);
      #1;
      chk("b_rel2", outs(1), mk(0, 3'd0, 8'h1B, 1, 0, 0, 1, 4'b0000, 3'd0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
